dual_parity_checker: RTL and testbench
======================================

// Module: dual_parity_checker
// PURPOSE
//  Receive-side checker for the two-lane ALU parity codeword. Each lane is a DATA_W-bit data word, one shared
//  control bit and one parity bit. Registers each accepted codeword and flags per-lane parity errors.
//  Keeps saturating error statistics and a link-health state machine.
//  Sits between the ALU datapath boundary and the consumer, on a valid/ready stream.
// PARAMETERS
//  DATA_W    8   data bits per lane
//  CNT_W     16  width of each saturating error counter
//  GOOD_RUN  4   consecutive clean words needed for DEGRADED->OK
//  ERR_RUN   3   consecutive error words needed for DEGRADED->FAULT
// PORTS
//  clk        in   1         clock; all logic on rising edge
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   1         input codeword valid
//  in_ready   out  1         checker can accept
//  in_dat_a   in   DATA_W    lane A data
//  in_dat_b   in   DATA_W    lane B data
//  in_ctl     in   1         shared control bit, covered by both lane parities
//  in_par_a   in   1         lane A parity
//  in_par_b   in   1         lane B parity
//  out_valid  out  1         checked word valid
//  out_ready  in   1         consumer accepts
//  out_dat_a  out  DATA_W    registered lane A data
//  out_dat_b  out  DATA_W    registered lane B data
//  out_err_a  out  1         lane A parity failed for this word
//  out_err_b  out  1         lane B parity failed for this word
//  clr_stats  in   1         clear counters, sticky flags, and FAULT
//  err_cnt_a  out  CNT_W     lane A error count, saturating
//  err_cnt_b  out  CNT_W     lane B error count, saturating
//  sticky_err out  2         {b,a} sticky error flags
//  link_state out  2         0=OK 1=DEGRADED 2=FAULT
// BEHAVIOUR
//  - Reset: all outputs 0; out_valid=0, counters=0, sticky=0, link_state=OK, run counters=0.
//  - Lane check: a lane codeword is good when XOR(dat, ctl, par) == 0; err = that XOR value.
//  - Handshake: in_ready = !out_valid | out_ready. Accept = in_valid & in_ready.
//  - Latency is 1 cycle from accept to out_valid. Back-to-back accepts are supported at full rate.
//  - out_* hold stable while out_valid & !out_ready. Inputs are ignored when no accept occurs.
//  - Statistics and FSM update only on accept. A word with any lane error is an "error word".
//  - err_cnt_x +1 on its lane error; holds at 2^CNT_W-1; sticky_err[x] is set on its lane error.
//  - FSM transitions (on accept):
//      OK       -> DEGRADED  on an error word.
//      DEGRADED -> FAULT     when the error-run count reaches ERR_RUN.
//      DEGRADED -> OK        when the clean-run count reaches GOOD_RUN.
//      An error word zeroes the clean-run count; a clean word zeroes the error-run count.
//  - FAULT is absorbing and does not stall the stream; only clr_stats or rst leave it.
//  - clr_stats on the same cycle as an accept: clear first, then apply that word.
//    Example: error word gives count=1 and state=DEGRADED.
//  - Run counters saturate at their threshold. ERR_RUN=1 means the first DEGRADED error word faults.
//  - rst mid-transfer drops any held output word; no partial state survives.
// CONFIGURATION
//  DPC_ERR_LOG_EN defined:
//    Adds ports log_valid(out,1) and log_word(out,2*DATA_W+3).
//    The first error word after reset or clr_stats is captured as {ctl,par_b,dat_b,par_a,dat_a}
//    and log_valid is set. Later errors do not overwrite the capture; clr_stats clears it.
//  Macro undefined: no log ports and no log logic.
// STRUCTURE
//  - dpc_pkg:
//      typedef link_state_e {OK, DEGRADED, FAULT}
//      function lane_err(dat, ctl, par)
//      localparam ST_W=2
//  - Sub-module dpc_lane_stats, instantiated twice.
//      Inputs: accept strobe, lane err, clr_stats.
//      Holds the saturating counter and sticky bit.
//  - The top holds the output register, the handshake and the FSM.
// TESTING
//  1. Reset, then stream 3 clean words (dat_a=8'hA5, ctl=0, par_a=0) with out_ready=1.
//     -> 3 outputs with err=0, one cycle later each; link_state=OK.
//  2. dat_a=8'h01, ctl=0, par_a=0
//     -> out_err_a=1, err_cnt_a=1, sticky=2'b01, DEGRADED; then 4 clean words -> OK.
//  3. 3 consecutive lane-B error words -> FAULT; then 10 clean words -> still FAULT.
//     Then clr_stats -> OK, counters 0.
//  4. out_ready=0 with 2 words offered -> one accepted, in_ready=0, out_* stable.
//     Then release -> second word follows with no loss or duplicate.
//  5. Force err_cnt_a to 2^CNT_W-1 (CNT_W=4, 16 errors) -> stays 15.
//     clr_stats with a simultaneous error word -> 1.
//  6. DPC_ERR_LOG_EN: two error words -> log_word equals the first; log_valid=1.

Source files
------------

// File: rtl/dpc_pkg.sv
// Shared types and helpers for the dual-lane parity checker.
// Holds the link-health encoding and the per-lane parity check.
package dpc_pkg;

  localparam int ST_W       = 2;
  localparam int MAX_DATA_W = 64;

  typedef enum logic [ST_W-1:0] {
    OK       = 2'd0,
    DEGRADED = 2'd1,
    FAULT    = 2'd2
  } link_state_e;

  // Callers zero-extend their lane data to MAX_DATA_W; extra zeros leave the XOR unchanged.
  function automatic logic lane_err(input logic [MAX_DATA_W-1:0] dat,
                                    input logic                  ctl,
                                    input logic                  par);
    return (^dat) ^ ctl ^ par;
  endfunction

endpackage

// File: rtl/dpc_lane_stats.sv
// Per-lane saturating error counter and sticky error flag, updated on accepted words.
// Clear and a simultaneous accepted error resolve as clear-then-count.
module dpc_lane_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc,
  input  logic             err,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sticky
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_base;
  logic             sticky_base;

  always_comb begin
    cnt_base    = clr ? '0   : cnt;
    sticky_base = clr ? 1'b0 : sticky;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      sticky <= 1'b0;
    end else if (acc && err) begin
      cnt    <= (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_W'(1);
      sticky <= 1'b1;
    end else begin
      cnt    <= cnt_base;
      sticky <= sticky_base;
    end
  end

endmodule

// File: rtl/dual_parity_checker.sv
// Two-lane parity checker with error stats and link-health FSM; optional first-error log under DPC_ERR_LOG_EN.
// 1-cycle latency; in_ready = !out_valid | out_ready, output word held stable under backpressure.
module dual_parity_checker
  import dpc_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 16,
  parameter int GOOD_RUN = 4,
  parameter int ERR_RUN  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_dat_a,
  input  logic [DATA_W-1:0] in_dat_b,
  input  logic              in_ctl,
  input  logic              in_par_a,
  input  logic              in_par_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_dat_a,
  output logic [DATA_W-1:0] out_dat_b,
  output logic              out_err_a,
  output logic              out_err_b,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  err_cnt_a,
  output logic [CNT_W-1:0]  err_cnt_b,
  output logic [1:0]        sticky_err,
  output logic [ST_W-1:0]   link_state
`ifdef DPC_ERR_LOG_EN
  ,
  output logic              log_valid,
  output logic [2*DATA_W+2:0] log_word
`endif
);

  localparam int RUN_MAX = (GOOD_RUN > ERR_RUN) ? GOOD_RUN : ERR_RUN;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] GOOD_LIM = RUN_W'(GOOD_RUN);
  localparam logic [RUN_W-1:0] ERR_LIM  = RUN_W'(ERR_RUN);

  logic accept;
  logic err_a;
  logic err_b;
  logic err_word;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign err_a    = lane_err(MAX_DATA_W'(in_dat_a), in_ctl, in_par_a);
  assign err_b    = lane_err(MAX_DATA_W'(in_dat_b), in_ctl, in_par_b);
  assign err_word = err_a || err_b;

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_dat_a <= '0;
      out_dat_b <= '0;
      out_err_a <= 1'b0;
      out_err_b <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_dat_a <= in_dat_a;
      out_dat_b <= in_dat_b;
      out_err_a <= err_a;
      out_err_b <= err_b;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  logic sticky_a;
  logic sticky_b;

  dpc_lane_stats #(.CNT_W(CNT_W)) u_stats_a (
    .clk    (clk),
    .rst    (rst),
    .acc    (accept),
    .err    (err_a),
    .clr    (clr_stats),
    .cnt    (err_cnt_a),
    .sticky (sticky_a)
  );

  dpc_lane_stats #(.CNT_W(CNT_W)) u_stats_b (
    .clk    (clk),
    .rst    (rst),
    .acc    (accept),
    .err    (err_b),
    .clr    (clr_stats),
    .cnt    (err_cnt_b),
    .sticky (sticky_b)
  );

  assign sticky_err = {sticky_b, sticky_a};

  link_state_e      state_q;
  link_state_e      state_n;
  link_state_e      state_base;
  logic [RUN_W-1:0] clean_run_q;
  logic [RUN_W-1:0] clean_run_n;
  logic [RUN_W-1:0] clean_base;
  logic [RUN_W-1:0] err_run_q;
  logic [RUN_W-1:0] err_run_n;
  logic [RUN_W-1:0] err_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= OK;
      clean_run_q <= '0;
      err_run_q   <= '0;
    end else begin
      state_q     <= state_n;
      clean_run_q <= clean_run_n;
      err_run_q   <= err_run_n;
    end
  end

  // A clear in the same cycle as an accept is applied before that word is scored.
  always_comb begin
    state_base  = clr_stats ? OK : state_q;
    clean_base  = clr_stats ? '0 : clean_run_q;
    err_base    = clr_stats ? '0 : err_run_q;
    state_n     = state_base;
    clean_run_n = clean_base;
    err_run_n   = err_base;
    if (accept) begin
      if (err_word) begin
        clean_run_n = '0;
        err_run_n   = (err_base >= ERR_LIM) ? ERR_LIM : err_base + RUN_W'(1);
      end else begin
        err_run_n   = '0;
        clean_run_n = (clean_base >= GOOD_LIM) ? GOOD_LIM : clean_base + RUN_W'(1);
      end
      unique case (state_base)
        OK: begin
          if (err_word) state_n = DEGRADED;
        end
        DEGRADED: begin
          if (err_word && (err_run_n >= ERR_LIM)) begin
            state_n = FAULT;
          end else if (!err_word && (clean_run_n >= GOOD_LIM)) begin
            state_n = OK;
          end
        end
        FAULT:   state_n = FAULT;
        default: state_n = OK;
      endcase
    end
  end

  assign link_state = state_q;

`ifdef DPC_ERR_LOG_EN
  // Only the first error word since reset or clear is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      log_valid <= 1'b0;
      log_word  <= '0;
    end else if (accept && err_word && (clr_stats || !log_valid)) begin
      log_valid <= 1'b1;
      log_word  <= {in_ctl, in_par_b, in_dat_b, in_par_a, in_dat_a};
    end else if (clr_stats) begin
      log_valid <= 1'b0;
      log_word  <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_dual_parity_checker.sv
// Directed bench for dual_parity_checker with a cycle-level reference model and per-cycle compare.
module tb_dual_parity_checker;

  localparam int DATA_W   = 8;
  localparam int CNT_W    = 4;
  localparam int GOOD_RUN = 4;
  localparam int ERR_RUN  = 3;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_dat_a = '0;
  logic [DATA_W-1:0] in_dat_b = '0;
  logic              in_ctl = 1'b0;
  logic              in_par_a = 1'b0;
  logic              in_par_b = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_dat_a;
  logic [DATA_W-1:0] out_dat_b;
  logic              out_err_a;
  logic              out_err_b;
  logic              clr_stats = 1'b0;
  logic [CNT_W-1:0]  err_cnt_a;
  logic [CNT_W-1:0]  err_cnt_b;
  logic [1:0]        sticky_err;
  logic [1:0]        link_state;
`ifdef DPC_ERR_LOG_EN
  logic              log_valid;
  logic [2*DATA_W+2:0] log_word;
`endif

  always #5 clk = ~clk;

  dual_parity_checker #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .GOOD_RUN(GOOD_RUN), .ERR_RUN(ERR_RUN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_dat_a   (in_dat_a),
    .in_dat_b   (in_dat_b),
    .in_ctl     (in_ctl),
    .in_par_a   (in_par_a),
    .in_par_b   (in_par_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_dat_a  (out_dat_a),
    .out_dat_b  (out_dat_b),
    .out_err_a  (out_err_a),
    .out_err_b  (out_err_b),
    .clr_stats  (clr_stats),
    .err_cnt_a  (err_cnt_a),
    .err_cnt_b  (err_cnt_b),
    .sticky_err (sticky_err),
    .link_state (link_state)
`ifdef DPC_ERR_LOG_EN
    ,
    .log_valid  (log_valid),
    .log_word   (log_word)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_sent  = 0;
  int n_xfer  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: state as plain integers, advanced once per rising edge.
  logic        m_valid = 1'b0;
  logic [7:0]  m_dat_a = '0;
  logic [7:0]  m_dat_b = '0;
  logic        m_err_a = 1'b0;
  logic        m_err_b = 1'b0;
  int          m_cnt_a = 0;
  int          m_cnt_b = 0;
  logic [1:0]  m_sticky = '0;
  int          m_state = 0;
  int          m_crun = 0;
  int          m_erun = 0;
  logic        m_log_valid = 1'b0;
  logic [18:0] m_log_word = '0;

  always @(posedge clk) begin
    bit acc, ea, eb, ew;
    if (rst) begin
      m_valid = 0; m_cnt_a = 0; m_cnt_b = 0; m_sticky = '0;
      m_state = 0; m_crun = 0; m_erun = 0; m_log_valid = 0; m_log_word = '0;
    end else begin
      acc = in_valid && (!m_valid || out_ready);
      if (clr_stats) begin
        m_cnt_a = 0; m_cnt_b = 0; m_sticky = '0;
        m_state = 0; m_crun = 0; m_erun = 0; m_log_valid = 0; m_log_word = '0;
      end
      if (acc) begin
        ea = (^in_dat_a) ^ in_ctl ^ in_par_a;
        eb = (^in_dat_b) ^ in_ctl ^ in_par_b;
        ew = ea || eb;
        m_valid = 1; m_dat_a = in_dat_a; m_dat_b = in_dat_b; m_err_a = ea; m_err_b = eb;
        if (ea) begin m_cnt_a = (m_cnt_a < CNT_MAX) ? m_cnt_a + 1 : CNT_MAX; m_sticky[0] = 1'b1; end
        if (eb) begin m_cnt_b = (m_cnt_b < CNT_MAX) ? m_cnt_b + 1 : CNT_MAX; m_sticky[1] = 1'b1; end
        if (ew) begin
          m_crun = 0;
          m_erun = (m_erun < ERR_RUN) ? m_erun + 1 : ERR_RUN;
          if (!m_log_valid) begin
            m_log_valid = 1;
            m_log_word  = {in_ctl, in_par_b, in_dat_b, in_par_a, in_dat_a};
          end
        end else begin
          m_erun = 0;
          m_crun = (m_crun < GOOD_RUN) ? m_crun + 1 : GOOD_RUN;
        end
        if (m_state == 0 && ew) m_state = 1;
        else if (m_state == 1 && ew && m_erun >= ERR_RUN) m_state = 2;
        else if (m_state == 1 && !ew && m_crun >= GOOD_RUN) m_state = 0;
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", out_valid, m_valid);
      chk("in_ready", in_ready, !m_valid || out_ready);
      if (m_valid) begin
        chk("out_dat_a", out_dat_a, m_dat_a);
        chk("out_dat_b", out_dat_b, m_dat_b);
        chk("out_err_a", out_err_a, m_err_a);
        chk("out_err_b", out_err_b, m_err_b);
      end
      chk("err_cnt_a", err_cnt_a, m_cnt_a);
      chk("err_cnt_b", err_cnt_b, m_cnt_b);
      chk("sticky_err", sticky_err, m_sticky);
      chk("link_state", link_state, m_state);
`ifdef DPC_ERR_LOG_EN
      chk("log_valid", log_valid, m_log_valid);
      if (m_log_valid) chk("log_word", log_word, m_log_word);
`endif
      if (out_valid && out_ready) n_xfer++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic pa, input logic pb);
    bit took = 1'b0;
    in_dat_a = a; in_dat_b = b; in_ctl = c; in_par_a = pa; in_par_b = pb;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !took; k++) begin
      took = in_ready;
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    if (took) n_sent++;
    else begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready never 1, expected accept within 50 cycles (t=%0t)", $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1);
  end

  initial begin
    logic [18:0] exp_log;
    @(posedge clk); #2;
    chk_en = 1'b1;
    idle(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_link", link_state, 0);
    chk("rst_cnt_a", err_cnt_a, 0);
    chk("rst_sticky", sticky_err, 0);
    rst = 1'b0;

    // Clean stream
    repeat (3) begin
      send(8'hA5, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("t1_valid", out_valid, 1);
      chk("t1_dat_a", out_dat_a, 8'hA5);
      chk("t1_err_a", out_err_a, 0);
    end
    idle(2);
    chk("t1_link", link_state, 0);

    // Single lane-A error then recovery
    send(8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t2_err_a", out_err_a, 1);
    chk("t2_cnt_a", err_cnt_a, 1);
    chk("t2_sticky", sticky_err, 2'b01);
    chk("t2_degraded", link_state, 1);
    repeat (3) send(8'hA5, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t2_still_degraded", link_state, 1);
    send(8'hA5, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t2_ok", link_state, 0);

    // Error run to FAULT, absorbing, then clear
    send(8'hA5, 8'h07, 1'b0, 1'b0, 1'b0);
    send(8'hA5, 8'h07, 1'b0, 1'b0, 1'b0);
    chk("t3_degraded", link_state, 1);
    send(8'hA5, 8'h07, 1'b0, 1'b0, 1'b0);
    chk("t3_fault", link_state, 2);
    chk("t3_cnt_b", err_cnt_b, 3);
    chk("t3_sticky", sticky_err, 2'b11);
    repeat (10) send(8'hA5, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t3_fault_held", link_state, 2);
    clr_stats = 1'b1; idle(1); clr_stats = 1'b0;
    chk("t3_clr_link", link_state, 0);
    chk("t3_clr_cnt_a", err_cnt_a, 0);
    chk("t3_clr_cnt_b", err_cnt_b, 0);
    chk("t3_clr_sticky", sticky_err, 0);

    // Backpressure: hold a word, second word waits, then both delivered once
    idle(1);
    out_ready = 1'b0;
    send(8'h11, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t4_valid", out_valid, 1);
    chk("t4_dat_a", out_dat_a, 8'h11);
    fork
      send(8'h22, 8'h00, 1'b0, 1'b0, 1'b0);
      begin
        repeat (3) begin
          @(posedge clk); #1;
          chk("t4_stall_ready", in_ready, 0);
          chk("t4_stall_dat", out_dat_a, 8'h11);
        end
        out_ready = 1'b1;
      end
    join
    chk("t4_second_dat", out_dat_a, 8'h22);
    idle(2);
    chk("t4_xfer_count", n_xfer, n_sent);

    // Counter saturation, then clear with simultaneous error
    clr_stats = 1'b1; idle(1); clr_stats = 1'b0;
    repeat (17) send(8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t5_sat", err_cnt_a, 15);
    clr_stats = 1'b1;
    send(8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    clr_stats = 1'b0;
    chk("t5_clr_err_cnt", err_cnt_a, 1);
    chk("t5_clr_err_state", link_state, 1);
    chk("t5_clr_err_sticky", sticky_err, 2'b01);

`ifdef DPC_ERR_LOG_EN
    clr_stats = 1'b1; idle(1); clr_stats = 1'b0;
    send(8'h01, 8'hA5, 1'b0, 1'b0, 1'b0);
    send(8'hA5, 8'h07, 1'b0, 1'b0, 1'b0);
    exp_log = {1'b0, 1'b0, 8'hA5, 1'b0, 8'h01};
    chk("t6_log_valid", log_valid, 1);
    chk("t6_log_word", log_word, exp_log);
`else
    exp_log = '0;
`endif
    idle(2);
    chk("t5_xfer_count", n_xfer, n_sent);

    // Reset while a word is held
    out_ready = 1'b0;
    send(8'h33, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; idle(1); rst = 1'b0;
    chk("t7_drop_valid", out_valid, 0);
    chk("t7_cnt_a", err_cnt_a, 0);
    chk("t7_link", link_state, 0);
    out_ready = 1'b1;
    idle(3);
    chk("t7_no_xfer", n_xfer, n_sent - 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
